// File: rtl/meteor_rand_pkg.sv
// meteor_rand_pkg: shared types and constants for the meteor spawn generator.
// The generator flavour is selected by METEOR_RAND_LFSR_EN (see rand_lfsr32).
package meteor_rand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIX  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Galois taps for the right-shift 32-bit LFSR
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/rand_lfsr32.sv
// rand_lfsr32: 32-bit pseudo-random source advancing every clock.
// METEOR_RAND_LFSR_EN defined -> right-shift Galois LFSR seeded from `seed`.
// METEOR_RAND_LFSR_EN undefined -> plain wrapping up-counter starting at 0.
module rand_lfsr32
    import meteor_rand_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] seed,
    output logic [31:0] rng
);

`ifdef METEOR_RAND_LFSR_EN
    // LFSR step; an all-zero state would lock up, so it is reseeded
    always_ff @(posedge Clk) begin
        if (Reset)
            rng <= seed;
        else if (rng == 32'h0)
            rng <= seed;
        else
            rng <= (rng >> 1) ^ (rng[0] ? LFSR_TAPS : 32'h0);
    end
`else
    // Counter step; the seed has no meaning here and the reset value is zero
    always_ff @(posedge Clk) begin
        if (Reset)
            rng <= seed & 32'h0;
        else
            rng <= rng + 32'd1;
    end
`endif

endmodule

// File: rtl/meteor_rand_gen.sv
// meteor_rand_gen: per-channel spawn record generator behind a ready/valid
// handshake. Generator flavour chosen by METEOR_RAND_LFSR_EN in rand_lfsr32.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready=1, waiting for req; captures sample/channel/sign
// FIX     | converts the captured sample into the output record
// HOLD    | record valid and stable until ack
module meteor_rand_gen
    import meteor_rand_pkg::*;
#(
    parameter int          POS_W   = 10,
    parameter int          POS_MAX = 640,
    parameter int          SPD_W   = 3,
    parameter int          NUM_CH  = 4,
    parameter logic [31:0] SEED    = DEFAULT_SEED,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             req,
    input  logic [CH_W-1:0]  req_ch,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [CH_W-1:0]  out_ch,
    output logic [POS_W-1:0] new_pos,
    output logic [SPD_W-1:0] x_speed,
    output logic [SPD_W-1:0] y_speed,
    output logic             sign
);

    localparam int SMP_W = POS_W + 2 * SPD_W;

    state_t             state, state_nxt;
    logic [31:0]        rng;
    logic [SMP_W-1:0]   sample;
    logic [CH_W-1:0]    ch_in, ch_q;
    logic               sgn_q;
    logic [NUM_CH-1:0]  sign_bits;
    logic [POS_W-1:0]   raw, pos_lim;
    logic [SPD_W-1:0]   x_fld, y_fld;

    rand_lfsr32 u_rng (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (SEED),
        .rng   (rng)
    );

    // Out-of-range channels fold onto channel 0
    assign ch_in = (int'(req_ch) < NUM_CH) ? req_ch : '0;
    assign ready = (state == ST_IDLE);

    // POS_MAX is above half the raw range, so one conditional subtract suffices
    assign raw     = sample[POS_W-1:0];
    assign pos_lim = ({1'b0, raw} < (POS_W+1)'(POS_MAX)) ? raw : raw - POS_W'(POS_MAX);
    assign x_fld   = sample[POS_W +: SPD_W];
    assign y_fld   = sample[POS_W+SPD_W +: SPD_W];

    // Per-channel direction bits, all flipped once per frame
    always_ff @(posedge Clk) begin
        if (Reset)
            sign_bits <= '0;
        else if (frame_tick)
            sign_bits <= ~sign_bits;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_HOLD;
            ST_HOLD: if (ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture on acceptance, build the record in FIX, release on ack
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sample  <= '0;
            ch_q    <= '0;
            sgn_q   <= 1'b0;
            valid   <= 1'b0;
            out_ch  <= '0;
            new_pos <= '0;
            x_speed <= '0;
            y_speed <= '0;
            sign    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        sample <= rng[SMP_W-1:0];
                        ch_q   <= ch_in;
                        sgn_q  <= sign_bits[ch_in];
                    end
                end
                ST_FIX: begin
                    valid   <= 1'b1;
                    out_ch  <= ch_q;
                    new_pos <= pos_lim;
                    x_speed <= (x_fld == '0) ? SPD_W'(1) : x_fld;
                    y_speed <= (y_fld == '0) ? SPD_W'(1) : y_fld;
                    sign    <= sgn_q;
                end
                ST_HOLD: begin
                    if (ack)
                        valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_meteor_rand_gen.sv
// tb_meteor_rand_gen: table-driven vectors plus a scoreboard fed by a
// reference model of the generator, sign bits and handshake.
module tb_meteor_rand_gen;

    localparam int          POS_W   = 10;
    localparam int          POS_MAX = 640;
    localparam int          SPD_W   = 3;
    localparam int          NUM_CH  = 5;   // 3-bit req_ch, so 5..7 are out of range
    localparam int          CH_W    = 3;
    localparam logic [31:0] SEED    = 32'h0000_0001;
`ifdef METEOR_RAND_LFSR_EN
    localparam logic [31:0] RST_RNG = SEED;
`else
    localparam logic [31:0] RST_RNG = 32'h0;
`endif

    logic             Clk, Reset, frame_tick, req, ready, valid, ack, sign;
    logic [CH_W-1:0]  req_ch, out_ch;
    logic [POS_W-1:0] new_pos;
    logic [SPD_W-1:0] x_speed, y_speed;

    meteor_rand_gen #(
        .POS_W(POS_W), .POS_MAX(POS_MAX), .SPD_W(SPD_W),
        .NUM_CH(NUM_CH), .SEED(SEED)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .req(req),
        .req_ch(req_ch), .ready(ready), .valid(valid), .ack(ack),
        .out_ch(out_ch), .new_pos(new_pos), .x_speed(x_speed),
        .y_speed(y_speed), .sign(sign)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [POS_W-1:0] pos;
        logic [SPD_W-1:0] xs;
        logic [SPD_W-1:0] ys;
        logic             sgn;
    } rec_t;

    typedef struct {
        int unsigned      target;
        logic [CH_W-1:0]  ch;
        logic [CH_W-1:0]  exp_ch;
        logic [POS_W-1:0] exp_pos;
        logic [SPD_W-1:0] exp_x;
        logic [SPD_W-1:0] exp_y;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    rec_t              sb_q[$];
    rec_t              last_rec;
    logic [31:0]       m_rng;
    logic [NUM_CH-1:0] m_sign;
    int                m_state;
    logic              prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic rec_t model_rec(input logic [31:0] r, input logic [CH_W-1:0] c,
                                       input logic [NUM_CH-1:0] s);
        rec_t             m;
        logic [POS_W-1:0] rw;
        m.ch  = (c < NUM_CH) ? c : '0;
        rw    = r[POS_W-1:0];
        m.pos = (rw >= POS_MAX) ? rw - 10'(POS_MAX) : rw;
        m.xs  = r[POS_W +: SPD_W];
        m.ys  = r[POS_W+SPD_W +: SPD_W];
        if (m.xs == 0) m.xs = 1;
        if (m.ys == 0) m.ys = 1;
        m.sgn = s[m.ch];
        return m;
    endfunction

    // Reference model: generator, sign bits, acceptance -> scoreboard push
    always @(posedge Clk) begin
        if (Reset) begin
            m_rng   <= RST_RNG;
            m_sign  <= '0;
            m_state <= 0;
            sb_q.delete();
        end else begin
`ifdef METEOR_RAND_LFSR_EN
            m_rng <= (m_rng == 32'h0) ? SEED : ((m_rng >> 1) ^ (m_rng[0] ? 32'h8020_0003 : 32'h0));
`else
            m_rng <= m_rng + 32'd1;
`endif
            if (frame_tick) m_sign <= ~m_sign;
            case (m_state)
                0: if (req) begin
                    sb_q.push_back(model_rec(m_rng, req_ch, m_sign));
                    m_state <= 1;
                end
                1: m_state <= 2;
                default: if (ack) m_state <= 0;
            endcase
        end
    end

    // Scoreboard pop on each rising valid
    always @(negedge Clk) begin
        if (valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=valid_rise required=no_record");
            end else begin
                last_rec = sb_q.pop_front();
                check("sb_ch",  32'(out_ch),  32'(last_rec.ch));
                check("sb_pos", 32'(new_pos), 32'(last_rec.pos));
                check("sb_x",   32'(x_speed), 32'(last_rec.xs));
                check("sb_y",   32'(y_speed), 32'(last_rec.ys));
                check("sb_sgn", 32'(sign),    32'(last_rec.sgn));
            end
        end
        prev_valid = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input string name);
        int n = 1;
        while (!valid && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check(name, 32'(n), 32'd2);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge Clk);
        ack = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{0,     3'd0, 3'd0, 10'd0,   3'd1, 3'd1};
        vt[1] = '{700,   3'd2, 3'd2, 10'd60,  3'd1, 3'd1};
        vt[2] = '{1664,  3'd5, 3'd0, 10'd0,   3'd1, 3'd1};
        vt[3] = '{8191,  3'd4, 3'd4, 10'd383, 3'd7, 3'd1};
        vt[4] = '{10879, 3'd1, 3'd1, 10'd639, 3'd2, 3'd1};
        vt[5] = '{24581, 3'd3, 3'd3, 10'd5,   3'd1, 3'd3};
        vt[6] = '{28772, 3'd7, 3'd0, 10'd100, 3'd4, 3'd3};

        Reset = 1'b1; frame_tick = 1'b0; req = 1'b0; req_ch = '0; ack = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pos",   32'(new_pos), 32'd0);
        check("rst_x",     32'(x_speed), 32'd0);
        Reset = 1'b0;

`ifndef METEOR_RAND_LFSR_EN
        for (int i = 0; i < 7; i++) begin
            int n = 0;
            while (m_rng != vt[i].target && n < 40000) begin
                @(negedge Clk);
                n++;
            end
            if (m_rng != vt[i].target) begin
                checks++;
                failures++;
                $display("FAIL vec%0d_reach actual=0x%0h required=0x%0h", i, m_rng, vt[i].target);
            end
            req = 1'b1; req_ch = vt[i].ch;
            @(negedge Clk);
            req = 1'b0;
            wait_valid($sformatf("vec%0d_latency", i));
            check($sformatf("vec%0d_ch", i),  32'(out_ch),  32'(vt[i].exp_ch));
            check($sformatf("vec%0d_pos", i), 32'(new_pos), 32'(vt[i].exp_pos));
            check($sformatf("vec%0d_x", i),   32'(x_speed), 32'(vt[i].exp_x));
            check($sformatf("vec%0d_y", i),   32'(y_speed), 32'(vt[i].exp_y));
            do_ack();
            check($sformatf("vec%0d_ack_valid", i), 32'(valid), 32'd0);
        end
`endif

        // Continuous req, late ack: record held, next one at minimum period
        req = 1'b1; req_ch = 3'd3;
        begin
            int n = 0;
            while (!valid && n < 10) begin
                @(negedge Clk);
                n++;
            end
            check("hs_latency", 32'(n), 32'd2);
        end
        check("hs_ready_v", 32'(ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            check("hs_hold_valid", 32'(valid),   32'd1);
            check("hs_hold_ready", 32'(ready),   32'd0);
            check("hs_hold_pos",   32'(new_pos), 32'(last_rec.pos));
            check("hs_hold_x",     32'(x_speed), 32'(last_rec.xs));
        end
        do_ack();
        check("hs_ack_valid", 32'(valid), 32'd0);
        check("hs_ack_ready", 32'(ready), 32'd1);
        @(negedge Clk);
        check("hs_reacc_valid", 32'(valid), 32'd0);
        check("hs_reacc_ready", 32'(ready), 32'd0);
        @(negedge Clk);
        check("hs_next_valid", 32'(valid), 32'd1);
        req = 1'b0;
        do_ack();

        // Reset while a record is held
        req = 1'b1; req_ch = 3'd4;
        @(negedge Clk);
        req = 1'b0;
        wait_valid("rh_latency");
        Reset = 1'b1;
        @(negedge Clk);
        check("rh_valid", 32'(valid),   32'd0);
        check("rh_ready", 32'(ready),   32'd1);
        check("rh_pos",   32'(new_pos), 32'd0);
        check("rh_x",     32'(x_speed), 32'd0);
        check("rh_y",     32'(y_speed), 32'd0);
        check("rh_ch",    32'(out_ch),  32'd0);
        check("rh_sign",  32'(sign),    32'd0);
        Reset = 1'b0;
        req = 1'b1; req_ch = 3'd2;
        @(negedge Clk);
        req = 1'b0;
        wait_valid("rh_first_latency");
        check("rh_first_pos", 32'(new_pos), 32'(RST_RNG[POS_W-1:0]));
        check("rh_first_x",   32'(x_speed), 32'd1);
        do_ack();

        // Sign: three ticks, then request channel 1
        repeat (3) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            @(negedge Clk);
        end
        req = 1'b1; req_ch = 3'd1;
        @(negedge Clk);
        req = 1'b0;
        wait_valid("sg_latency");
        check("sg_after3", 32'(sign), 32'd1);
        do_ack();
        req = 1'b1; req_ch = 3'd1; frame_tick = 1'b1;
        @(negedge Clk);
        req = 1'b0; frame_tick = 1'b0;
        wait_valid("sg_pre_latency");
        check("sg_pretoggle", 32'(sign), 32'd1);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        check("sg_hold", 32'(sign), 32'd1);
        do_ack();
        req = 1'b1; req_ch = 3'd5;
        @(negedge Clk);
        req = 1'b0;
        wait_valid("oor_latency");
        check("oor_ch",   32'(out_ch), 32'd0);
        check("oor_sign", 32'(sign),   32'd1);
        do_ack();

        repeat (2) @(negedge Clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
